// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared types and helpers for the polyphase multiply-accumulate datapath.
//   clog2      : ceiling log2 for parameter derivation (clog2(1) = 0)
//   sat_max    : most positive signed value of a given width (width <= 64)
//   sat_min    : most negative signed value of a given width (width <= 64)
//   tag_t      : per-sample control tag carried alongside the datapath
// -----------------------------------------------------------------------------
package mac_pkg;

  // Tag channel field is fixed-width so the struct can live in the package;
  // the top zero-extends its CHAN_W-bit index into it (N_CHAN <= 256).
  localparam int MAX_CHAN_W = 8;

  typedef struct packed {
    logic                  valid;
    logic [MAX_CHAN_W-1:0] chan;
    logic                  sload;
    logic                  dump;
  } tag_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// -----------------------------------------------------------------------------
// mac_sat_add
// Combinational accumulator update: load the sign-extended product, or add it
// to the accumulator with clamping to the signed WIDTH_OUT range.
//   acc      in  WIDTH_OUT  current accumulator value
//   prod_ext in  WIDTH_OUT  sign-extended product
//   sload    in  1          1: next = prod_ext (never saturates)
//   next     out WIDTH_OUT  updated accumulator value
//   sat      out 1          the add overflowed and was clamped
// -----------------------------------------------------------------------------
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int WIDTH_OUT = 40
) (
  input  logic signed [WIDTH_OUT-1:0] acc,
  input  logic signed [WIDTH_OUT-1:0] prod_ext,
  input  logic                        sload,
  output logic signed [WIDTH_OUT-1:0] next,
  output logic                        sat
);

  localparam logic signed [63:0] MAX64 = sat_max(WIDTH_OUT);
  localparam logic signed [63:0] MIN64 = sat_min(WIDTH_OUT);
  localparam logic signed [WIDTH_OUT-1:0] MAX_V = MAX64[WIDTH_OUT-1:0];
  localparam logic signed [WIDTH_OUT-1:0] MIN_V = MIN64[WIDTH_OUT-1:0];

  // One guard bit: overflow iff the two top bits of the sum disagree, and the
  // guard bit then gives the true sign of the unclamped result.
  logic [WIDTH_OUT:0] sum;
  logic               ovf;

  assign sum = {acc[WIDTH_OUT-1], acc} + {prod_ext[WIDTH_OUT-1], prod_ext};
  assign ovf = sum[WIDTH_OUT] ^ sum[WIDTH_OUT-1];

  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch can be inferred.
    next = prod_ext;
    sat  = 1'b0;
    if (!sload) begin
      if (ovf) begin
        sat  = 1'b1;
        next = sum[WIDTH_OUT] ? MIN_V : MAX_V;
      end else begin
        next = sum[WIDTH_OUT-1:0];
      end
    end
  end

endmodule

// File: rtl/mac_polyphase_acc.sv
// -----------------------------------------------------------------------------
// mac_polyphase_acc
// Pipelined signed MAC with one multiplier shared by N_CHAN interleaved
// accumulators. Accepted sample at edge k -> accumulator update and optional
// result strobe at edge k+3.
//   clk, reset        clock, synchronous active-high reset
//   in_valid          qualifies chan/accum_sload/accum_dump/dataa/datab
//   chan              accumulator index
//   accum_sload       1: load product, 0: saturating add of product
//   accum_dump        1: emit updated accumulator value
//   dataa, datab      signed operands
//   out_valid         one-cycle strobe for result/out_chan/out_sat
//   out_chan          channel of result
//   result            accumulator value after the update
//   out_sat           the update producing result saturated
// -----------------------------------------------------------------------------
module mac_polyphase_acc
  import mac_pkg::*;
#(
  parameter  int WIDTH_IN  = 16,
  parameter  int WIDTH_OUT = 40,
  parameter  int N_CHAN    = 4,
  localparam int CHAN_W    = (clog2(N_CHAN) < 1) ? 1 : clog2(N_CHAN)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [CHAN_W-1:0]           chan,
  input  logic                        accum_sload,
  input  logic                        accum_dump,
  input  logic signed [WIDTH_IN-1:0]  dataa,
  input  logic signed [WIDTH_IN-1:0]  datab,
  output logic                        out_valid,
  output logic [CHAN_W-1:0]           out_chan,
  output logic signed [WIDTH_OUT-1:0] result,
  output logic                        out_sat
);

  localparam logic [MAX_CHAN_W:0] N_CHAN_V = (MAX_CHAN_W + 1)'(N_CHAN);

  // Stage 1 operand/tag registers; stage 2 is two registers deep (multiplier
  // output, then product) so the accumulate edge lands at k+3.
  tag_t                         s1_tag, m_tag, p_tag;
  logic signed [WIDTH_IN-1:0]   s1_a, s1_b;
  logic signed [2*WIDTH_IN-1:0] m_prod, p_prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_tag <= '0;
      m_tag  <= '0;
      p_tag  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      s1_tag <= '{valid: in_valid, chan: MAX_CHAN_W'(chan),
                  sload: accum_sload, dump: accum_dump};
      m_tag  <= s1_tag;
      p_tag  <= m_tag;
    end
  end

  // NOTE: datapath registers carry no reset; the tag valid bit alone decides whether they matter.
  always_ff @(posedge clk) begin
    s1_a   <= dataa;
    s1_b   <= datab;
    m_prod <= s1_a * s1_b;
    p_prod <= m_prod;
  end

  // Stage 3: read-modify-write of one accumulator within a single stage, so
  // back-to-back samples on the same channel need no forwarding.
  logic signed [WIDTH_OUT-1:0] acc [N_CHAN];
  logic [CHAN_W-1:0]           chan_idx;
  logic                        chan_ok;
  logic signed [WIDTH_OUT-1:0] acc_rd, prod_ext, next;
  logic                        sat;

  assign chan_idx = p_tag.chan[CHAN_W-1:0];
  assign chan_ok  = {1'b0, p_tag.chan} < N_CHAN_V;
  assign acc_rd   = chan_ok ? acc[chan_idx] : '0;
  assign prod_ext = WIDTH_OUT'(p_prod);

  mac_sat_add #(
    .WIDTH_OUT (WIDTH_OUT)
  ) u_sat_add (
    .acc      (acc_rd),
    .prod_ext (prod_ext),
    .sload    (p_tag.sload),
    .next     (next),
    .sat      (sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the accumulator array is reset because a first update without sload must add to zero.
      for (int i = 0; i < N_CHAN; i++) acc[i] <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      result    <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (p_tag.valid && chan_ok) begin
        acc[chan_idx] <= next;
        if (p_tag.dump) begin
          out_valid <= 1'b1;
          out_chan  <= chan_idx;
          result    <= next;
          out_sat   <= sat;
        end
      end
    end
  end

endmodule

// File: doc/mac_polyphase_acc.md
Name: mac_polyphase_acc

Overview:
Parametrised, pipelined, multi-channel signed multiply-accumulate for the polyphase filter datapath. One multiplier is time-shared across N_CHAN interleaved channels (filter phases), each with its own accumulator. The block adds valid qualification, per-sample channel tagging, saturating accumulation and an explicit dump/output strobe. It sits between the coefficient/sample fetch logic and the decimated output stage.

Parameters:
WIDTH_IN, 16, signed width of dataa/datab; must be >= 2.
WIDTH_OUT, 40, signed accumulator/result width; must be >= 2*WIDTH_IN.
N_CHAN, 4, number of independent accumulators; must be >= 1.
CHAN_W, clog2(N_CHAN) with a minimum of 1, channel index width; derived localparam, not overridden.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  qualifies dataa/datab/chan/accum_sload/accum_dump this cycle
chan  in  CHAN_W  accumulator index for this sample
accum_sload  in  1  1: accumulator loads the product; 0: accumulator adds the product
accum_dump  in  1  1: emit the updated accumulator value on result
dataa  in  WIDTH_IN  signed operand
datab  in  WIDTH_IN  signed operand
out_valid  out  1  one-cycle strobe; result/out_chan/out_sat valid
out_chan  out  CHAN_W  channel of the emitted result
result  out  WIDTH_OUT  signed accumulator value after the update
out_sat  out  1  saturation occurred on the update that produced result

Behaviour:
- Reset (synchronous, reset=1 at a clk edge): all N_CHAN accumulators = 0, all pipeline valid bits = 0, out_valid=0, result=0, out_chan=0, out_sat=0. In-flight samples are discarded. Samples presented while reset=1 are ignored.
- Stage 1 (edge after the input cycle): register dataa, datab, chan, accum_sload, accum_dump and in_valid.
- Stage 2: full signed product, 2*WIDTH_IN bits, registered and carried with its tags.
- Stage 3: read acc[chan] and form the next value.
  - sload=1: next = sign-extended product.
  - sload=0: next = acc[chan] + product, evaluated at WIDTH_OUT+1 bits. On overflow, clamp to +(2^(WIDTH_OUT-1)-1) or -(2^(WIDTH_OUT-1)). Set out_sat for this update only.
  - A sign-extended product alone never saturates.
  - Write next to acc[chan] in the same edge.
- Output: if the stage-3 sample has dump=1, then on that edge out_valid=1, result=next, out_chan=chan, out_sat=sat. Otherwise out_valid=0 and result/out_chan/out_sat hold their last values.
- Latency: a sample accepted with in_valid=1 at edge k produces out_valid=1 at edge k+3.
- Throughput: one sample per cycle, any channel order. Back-to-back samples on the same channel are legal and hazard-free, because the accumulator is read and written in stage 3 only.
- Bubbles: in_valid=0 propagates as a bubble. There is no accumulator change and no output.
- Out-of-range chan (chan >= N_CHAN when N_CHAN is not a power of 2): the sample is dropped at stage 3. No write, no out_valid.
- Saturation is non-sticky. A saturated accumulator keeps accumulating from its clamped value.
- No backpressure. The downstream consumer must accept every out_valid pulse.

Decomposition:
- Package mac_pkg:
  - function clog2;
  - functions sat_max(width) and sat_min(width);
  - a packed struct for the pipeline tag {valid, chan, sload, dump}.
- Sub-module mac_sat_add (combinational): inputs are the accumulator, the sign-extended product and sload; outputs are next and sat. It is instantiated once in stage 3 and is unit-testable alone.

Test Plan:
1. N_CHAN=1. Sequence {(3,4,sload=1), (-2,5), (7,-1,dump=1)}, back-to-back -> single out_valid exactly 3 cycles after the 3rd sample; result = 12-10-7 = -5, out_sat=0.
2. N_CHAN=4. Interleave chan 0,1,2,3,0,1,2,3 with dataa=chan+1, datab=10; sload=1 on the first round, dump=1 on the second -> four consecutive out_valid pulses with out_chan=0..3 and result=20,40,60,80.
3. WIDTH_IN=16, WIDTH_OUT=32. Two samples (-32768,-32768) on chan 0, first with sload=1, second with dump=1 -> result=2147483647, out_sat=1. A further (1,-1, dump=1) -> result=2147483646, out_sat=0.
4. Bubbles: in_valid toggles 1,0,0,1 on chan 2 with (5,5,sload), (2,3,dump) -> one out_valid with result=31. No pulse corresponds to the bubble cycles.
5. Reset mid-operation: load chan 1 with 100 via sload, then assert reset for 1 cycle while a dump sample is in stage 2 -> no out_valid. Then sample (1,1,dump) without sload on chan 1 -> result=1 (accumulator cleared).
6. N_CHAN=3 with chan=3 and dump=1 -> no out_valid, and acc[0..2] unchanged (checked by follow-up dumps of (0,0)).
